// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the control unit and the iterative
// multiply/divide unit. The control unit drives operands and start, and the
// unit returns HI/LO plus its status flags.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide unit feeding HI/LO.
// Both operations work on operand magnitudes, taking one step per cycle for
// WIDTH cycles. The sign is fixed up on the last step, so HI/LO change only
// on the edge that enters DONE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             isDiv_q, isDiv_d;
  logic             negLo_q, negLo_d;
  logic             negHi_q, negHi_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] accHi_q, accHi_d;
  logic [WIDTH-1:0] accLo_q, accLo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signedOp;
  logic             aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   remShift;
  logic             remGe;
  logic [WIDTH-1:0] stepHi, stepLo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] finalHi, finalLo;

  // Operand magnitudes and sign bookkeeping for an incoming request
  always_comb begin
    signedOp = ~bus.op[0];
    aNeg     = signedOp & bus.a[WIDTH-1];
    bNeg     = signedOp & bus.b[WIDTH-1];
    aMag     = aNeg ? (-bus.a) : bus.a;
    bMag     = bNeg ? (-bus.b) : bus.b;
  end

  // One shift-add or restoring-divide step, plus the sign-corrected result of that step
  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, mcand_q} : '0);
    remShift = {accHi_q, accLo_q[WIDTH-1]};
    remGe    = remShift >= {1'b0, mcand_q};
    if (isDiv_q) begin
      stepHi = remGe ? (remShift[WIDTH-1:0] - mcand_q) : remShift[WIDTH-1:0];
      stepLo = {accLo_q[WIDTH-2:0], remGe};
    end else begin
      {stepHi, stepLo} = {mulSum, accLo_q[WIDTH-1:1]};
    end
    prod = {stepHi, stepLo};
    if (isDiv_q) begin
      finalLo = negLo_q ? (-stepLo) : stepLo;
      finalHi = negHi_q ? (-stepHi) : stepHi;
    end else begin
      if (negLo_q) begin
        prod = -prod;
      end
      finalHi = prod[2*WIDTH-1:WIDTH];
      finalLo = prod[WIDTH-1:0];
    end
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequence
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    isDiv_d   = isDiv_q;
    negLo_d   = negLo_q;
    negHi_d   = negHi_q;
    divZero_d = divZero_q;
    mcand_d   = mcand_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          isDiv_d = bus.op[1];
          negLo_d = aNeg ^ bNeg;
          negHi_d = bus.op[1] & aNeg;
          mcand_d = bMag;
          accLo_d = aMag;
          accHi_d = '0;
          count_d = CNT_W'(WIDTH);
          if (bus.op[1] && (bus.b == '0)) begin
            divZero_d = 1'b1;
            state_d   = DONE;
          end else begin
            divZero_d = 1'b0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        accHi_d = stepHi;
        accLo_d = stepLo;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          hi_d    = finalHi;
          lo_d    = finalLo;
          state_d = DONE;
        end
      end
      DONE: begin
        divZero_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      isDiv_q   <= 1'b0;
      negLo_q   <= 1'b0;
      negHi_q   <= 1'b0;
      divZero_q <= 1'b0;
      mcand_q   <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      isDiv_q   <= isDiv_d;
      negLo_q   <= negLo_d;
      negHi_q   <= negHi_d;
      divZero_q <= divZero_d;
      mcand_q   <= mcand_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = (state_q == DONE) & divZero_q;

endmodule
